// File: rtl/jtag_ctap_ctrl_pkg.sv
// Shared definitions for the central-TAP command sequencer: register selects,
// opcodes, instruction/status layout and FSM states.
package jtag_ctap_ctrl_pkg;

  localparam int CTAP_REG_SEL_W = 2;
  localparam logic [CTAP_REG_SEL_W-1:0] CTAP_REG_SEL_INSTR   = 2'd0;
  localparam logic [CTAP_REG_SEL_W-1:0] CTAP_REG_SEL_ADDRESS = 2'd1;
  localparam logic [CTAP_REG_SEL_W-1:0] CTAP_REG_SEL_DATA0   = 2'd2;

  localparam logic [3:0] CTAP_OP_NOP   = 4'd0;
  localparam logic [3:0] CTAP_OP_READ  = 4'd1;
  localparam logic [3:0] CTAP_OP_WRITE = 4'd2;

  // Instruction: [3:0] op, [15:8] tile. Status: {ovr, tmo, err, busy, instr}.
  localparam int INSTR_W = 16;
  localparam int STAT_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } ctap_state_e;

  function automatic logic op_is_req(input logic [3:0] op);
    return (op == CTAP_OP_READ) || (op == CTAP_OP_WRITE);
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return !op_is_req(op) && (op != CTAP_OP_NOP);
  endfunction

endpackage

// File: rtl/jtag_ctap_timeout_cnt.sv
// Response-wait timer: restarts from zero on load, counts while enabled and
// flags expiry on the LIMIT-th enabled cycle.
module jtag_ctap_timeout_cnt #(
  parameter int unsigned LIMIT = 16'hFFFF,
  parameter int          CNT_W = 16
) (
  input  logic jtag_clk,
  input  logic jtag_rst_l,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge jtag_clk) begin
    if (!jtag_rst_l) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/jtag_ctap_ctrl.sv
// Central-TAP command sequencer: JTAG-written registers launch one UCB request
// per INSTRUCTION write. Optional response timeout under CTAP_CTRL_TIMEOUT_EN.
module jtag_ctap_ctrl
  import jtag_ctap_ctrl_pkg::*;
#(
  parameter int SCRATCH_W = 64,
  parameter int ADDR_W    = 40,
  parameter int TILE_W    = 8
`ifdef CTAP_CTRL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 16'hFFFF
`endif
) (
  input  logic                      jtag_clk,
  input  logic                      jtag_rst_l,
  input  logic [SCRATCH_W-1:0]      jtag_ctap_data,
  input  logic                      jtag_ctap_reg_wr_en,
  input  logic [CTAP_REG_SEL_W-1:0] jtag_ctap_reg_sel,
  output logic [SCRATCH_W-1:0]      ctap_jtag_data,
  output logic                      ctap_jtag_interrupt_bit,
  output logic                      req_val,
  input  logic                      req_rdy,
  output logic [1:0]                req_op,
  output logic [TILE_W-1:0]         req_tile,
  output logic [ADDR_W-1:0]         req_addr,
  output logic [SCRATCH_W-1:0]      req_data,
  input  logic                      rsp_val,
  input  logic                      rsp_err,
  input  logic [SCRATCH_W-1:0]      rsp_data,
  output logic                      busy
);

  ctap_state_e          state, state_nxt;
  logic [INSTR_W-1:0]   instr_r;
  logic [ADDR_W-1:0]    addr_r;
  logic [SCRATCH_W-1:0] data0_r;
  logic                 int_r, err_r, tmo_r, ovr_r;
  logic                 idle, instr_wr, tmo_expire;
  logic [3:0]           wr_op;

  assign idle     = (state == ST_IDLE);
  assign busy     = !idle;
  assign wr_op    = jtag_ctap_data[3:0];
  assign instr_wr = jtag_ctap_reg_wr_en && idle && (jtag_ctap_reg_sel == CTAP_REG_SEL_INSTR);

`ifdef CTAP_CTRL_TIMEOUT_EN
  jtag_ctap_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_timeout_cnt (
    .jtag_clk   (jtag_clk),
    .jtag_rst_l (jtag_rst_l),
    .load       ((state == ST_ISSUE) && req_rdy),
    .en         (state == ST_WAIT_RSP),
    .expire     (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  // NOTE: state and registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge jtag_clk) begin
    if (!jtag_rst_l) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    req_val   = 1'b0;
    case (state)
      ST_IDLE:     if (instr_wr) state_nxt = op_is_req(wr_op) ? ST_ISSUE : ST_DONE;
      ST_ISSUE: begin
        req_val = 1'b1;
        if (req_rdy) state_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: if (rsp_val || tmo_expire) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge jtag_clk) begin
    if (!jtag_rst_l) begin
      instr_r <= '0;
      addr_r  <= '0;
      data0_r <= '0;
      int_r   <= 1'b0;
      err_r   <= 1'b0;
      tmo_r   <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      if (jtag_ctap_reg_wr_en) begin
        if (!idle) begin
          ovr_r <= 1'b1;
        end else begin
          case (jtag_ctap_reg_sel)
            CTAP_REG_SEL_INSTR: begin
              instr_r <= jtag_ctap_data[INSTR_W-1:0];
              int_r   <= 1'b0;
              err_r   <= op_is_illegal(wr_op);
              tmo_r   <= 1'b0;
              ovr_r   <= 1'b0;
            end
            CTAP_REG_SEL_ADDRESS: addr_r  <= jtag_ctap_data[ADDR_W-1:0];
            CTAP_REG_SEL_DATA0:   data0_r <= jtag_ctap_data;
            default: ;
          endcase
        end
      end
      // A response arriving on the expiry cycle wins over the timeout.
      if (state == ST_WAIT_RSP) begin
        if (rsp_val) begin
          if (instr_r[3:0] == CTAP_OP_READ) data0_r <= rsp_data;
          if (rsp_err) err_r <= 1'b1;
        end else if (tmo_expire) begin
          tmo_r <= 1'b1;
          err_r <= 1'b1;
        end
      end
      if (state == ST_DONE) int_r <= 1'b1;
    end
  end

  assign ctap_jtag_interrupt_bit = int_r;
  assign req_op   = instr_r[1:0];
  assign req_tile = TILE_W'(instr_r[15:8]);
  assign req_addr = addr_r;
  assign req_data = data0_r;

  always_comb begin
    ctap_jtag_data = '0;
    case (jtag_ctap_reg_sel)
      CTAP_REG_SEL_DATA0:   ctap_jtag_data = data0_r;
      CTAP_REG_SEL_ADDRESS: ctap_jtag_data = {{(SCRATCH_W-ADDR_W){1'b0}}, addr_r};
      CTAP_REG_SEL_INSTR:   ctap_jtag_data = {{(SCRATCH_W-STAT_W){1'b0}},
                                              ovr_r, tmo_r, err_r, busy, instr_r};
      default:              ctap_jtag_data = '0;
    endcase
  end

endmodule

// File: tb/tb_jtag_ctap_ctrl.sv
// Scoreboard bench for jtag_ctap_ctrl: the driver pushes expected requests and
// completion status; an independent monitor pops and compares them.
module tb_jtag_ctap_ctrl;
  import jtag_ctap_ctrl_pkg::*;

  localparam int SCRATCH_W = 64;
  localparam int ADDR_W    = 40;
  localparam int TILE_W    = 8;

  logic                      jtag_clk, jtag_rst_l;
  logic [SCRATCH_W-1:0]      jtag_ctap_data;
  logic                      jtag_ctap_reg_wr_en;
  logic [CTAP_REG_SEL_W-1:0] jtag_ctap_reg_sel;
  logic [SCRATCH_W-1:0]      ctap_jtag_data;
  logic                      ctap_jtag_interrupt_bit;
  logic                      req_val, req_rdy;
  logic [1:0]                req_op;
  logic [TILE_W-1:0]         req_tile;
  logic [ADDR_W-1:0]         req_addr;
  logic [SCRATCH_W-1:0]      req_data;
  logic                      rsp_val, rsp_err;
  logic [SCRATCH_W-1:0]      rsp_data;
  logic                      busy;

  jtag_ctap_ctrl #(
    .SCRATCH_W(SCRATCH_W), .ADDR_W(ADDR_W), .TILE_W(TILE_W)
`ifdef CTAP_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .jtag_clk                (jtag_clk),
    .jtag_rst_l              (jtag_rst_l),
    .jtag_ctap_data          (jtag_ctap_data),
    .jtag_ctap_reg_wr_en     (jtag_ctap_reg_wr_en),
    .jtag_ctap_reg_sel       (jtag_ctap_reg_sel),
    .ctap_jtag_data          (ctap_jtag_data),
    .ctap_jtag_interrupt_bit (ctap_jtag_interrupt_bit),
    .req_val                 (req_val),
    .req_rdy                 (req_rdy),
    .req_op                  (req_op),
    .req_tile                (req_tile),
    .req_addr                (req_addr),
    .req_data                (req_data),
    .rsp_val                 (rsp_val),
    .rsp_err                 (rsp_err),
    .rsp_data                (rsp_data),
    .busy                    (busy)
  );

  initial jtag_clk = 1'b0;
  always #5 jtag_clk = ~jtag_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [7:0]  tile;
    logic [39:0] addr;
    logic [63:0] data;
  } req_t;

  req_t        exp_req_q[$];
  logic [63:0] exp_cpl_q[$];

  // Architectural model of the programmer-visible registers.
  logic [15:0] m_instr;
  logic [39:0] m_addr;
  logic [63:0] m_data0;
  bit          m_err, m_tmo, m_ovr;

  function automatic logic [63:0] m_status();
    return {44'h0, m_ovr, m_tmo, m_err, 1'b0, m_instr};
  endfunction

  task automatic model_reset();
    m_instr = '0; m_addr = '0; m_data0 = '0;
    m_err = 0; m_tmo = 0; m_ovr = 0;
  endtask

  task automatic tick();
    @(posedge jtag_clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [63:0] val);
    jtag_ctap_reg_wr_en = 1'b1;
    jtag_ctap_reg_sel   = sel;
    jtag_ctap_data      = val;
    tick();
    jtag_ctap_reg_wr_en = 1'b0;
    jtag_ctap_reg_sel   = CTAP_REG_SEL_INSTR;
    jtag_ctap_data      = {$urandom, $urandom};
  endtask

  // Register write while the sequencer is idle.
  task automatic host_write(input logic [1:0] sel, input logic [63:0] val);
    if (sel == CTAP_REG_SEL_ADDRESS) m_addr = val[39:0];
    if (sel == CTAP_REG_SEL_DATA0)   m_data0 = val;
    write_reg(sel, val);
  endtask

  task automatic readback(input logic [1:0] sel, input logic [63:0] exp, input string name);
    jtag_ctap_reg_sel = sel;
    @(negedge jtag_clk);
    check(name, ctap_jtag_data, exp);
    tick();
    jtag_ctap_reg_sel = CTAP_REG_SEL_INSTR;
  endtask

  task automatic wait_int();
    int n = 0;
    while (!ctap_jtag_interrupt_bit && n < 8) begin
      tick();
      n++;
    end
    check("completion_seen", 64'(ctap_jtag_interrupt_bit), 64'(1));
    tick();
  endtask

  task automatic pulse_rsp(input bit err, input logic [63:0] d);
    rsp_val = 1'b1; rsp_err = err; rsp_data = d;
    tick();
    rsp_val = 1'b0; rsp_err = 1'($urandom); rsp_data = {$urandom, $urandom};
  endtask

  // Handshake the request after rdy_dly stalled cycles; returns in WAIT_RSP cycle 0.
  task automatic accept_req(input int rdy_dly);
    repeat (rdy_dly) tick();
    req_rdy = 1'b1;
    tick();
    req_rdy = 1'b0;
  endtask

  task automatic start_cmd(input logic [15:0] instr);
    logic [3:0] op;
    bit rw;
    op = instr[3:0];
    rw = (op == CTAP_OP_READ) || (op == CTAP_OP_WRITE);
    m_instr = instr; m_ovr = 0; m_tmo = 0;
    m_err = !(rw || op == CTAP_OP_NOP);
    if (rw) exp_req_q.push_back('{instr[1:0], instr[15:8], m_addr, m_data0});
    else    exp_cpl_q.push_back(m_status());
    write_reg(CTAP_REG_SEL_INSTR, 64'(instr));
    check("int_cleared", 64'(ctap_jtag_interrupt_bit), 64'(0));
    check("req_val_next", 64'(req_val), 64'(rw));
  endtask

  task automatic run_cmd(input logic [15:0] instr, input int rdy_dly, input int rsp_dly,
                         input bit err, input logic [63:0] d, input bit busy_wr);
    bit rw;
    rw = (instr[3:0] == CTAP_OP_READ) || (instr[3:0] == CTAP_OP_WRITE);
    start_cmd(instr);
    if (!rw) begin
      tick();
      check("nonreq_int_2cyc", 64'(ctap_jtag_interrupt_bit), 64'(1));
      tick();
      return;
    end
    accept_req(rdy_dly);
    if (busy_wr) begin
      write_reg(CTAP_REG_SEL_DATA0, 64'h1);
      write_reg(CTAP_REG_SEL_INSTR, 64'h0001);
      m_ovr = 1;
    end
    if (instr[3:0] == CTAP_OP_READ) m_data0 = d;
    if (err) m_err = 1;
    exp_cpl_q.push_back(m_status());
    repeat (rsp_dly) tick();
    check("busy_before_rsp", 64'(busy), 64'(1));
    pulse_rsp(err, d);
    wait_int();
  endtask

  // Monitor: compares presented requests and completions against the scoreboard.
  logic prev_int = 1'b0;
  always @(negedge jtag_clk) begin
    if (jtag_rst_l) begin
      if (req_val) begin
        if (exp_req_q.size() == 0) begin
          check("unexpected_req", 64'(req_val), 64'(0));
        end else begin
          req_t e;
          e = exp_req_q[0];
          check("req_op_tile", 64'({req_op, req_tile}), 64'({e.op, e.tile}));
          check("req_addr", 64'(req_addr), 64'(e.addr));
          check("req_data", req_data, e.data);
          if (req_rdy) void'(exp_req_q.pop_front());
        end
      end
      if (ctap_jtag_interrupt_bit && !prev_int) begin
        if (exp_cpl_q.size() == 0) begin
          check("unexpected_cpl", 64'(ctap_jtag_interrupt_bit), 64'(0));
        end else begin
          logic [63:0] s;
          s = exp_cpl_q.pop_front();
          check("cpl_busy", 64'(busy), 64'(0));
          if (jtag_ctap_reg_sel == CTAP_REG_SEL_INSTR) check("cpl_status", ctap_jtag_data, s);
        end
      end
    end
    prev_int = ctap_jtag_interrupt_bit;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    jtag_rst_l = 1'b0; jtag_ctap_reg_wr_en = 1'b0; jtag_ctap_reg_sel = CTAP_REG_SEL_INSTR;
    jtag_ctap_data = '0; req_rdy = 1'b0; rsp_val = 1'b0; rsp_err = 1'b0; rsp_data = '0;
    model_reset();
    repeat (3) tick();
    jtag_rst_l = 1'b1;
    check("rst_req_val", 64'(req_val), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_int", 64'(ctap_jtag_interrupt_bit), 64'(0));
    check("rst_status", ctap_jtag_data, 64'(0));
    readback(CTAP_REG_SEL_ADDRESS, 64'(0), "rst_addr");
    readback(CTAP_REG_SEL_DATA0, 64'(0), "rst_data0");

    // Write command with fixed fields.
    host_write(CTAP_REG_SEL_ADDRESS, 64'h12_3456_7890);
    host_write(CTAP_REG_SEL_DATA0, 64'hDEAD_BEEF);
    run_cmd(16'h0302, 0, 2, 1'b0, 64'h5555, 1'b0);
    readback(CTAP_REG_SEL_ADDRESS, 64'h12_3456_7890, "t1_addr");
    readback(CTAP_REG_SEL_DATA0, 64'hDEAD_BEEF, "t1_data0");

    // Read with a long ready stall.
    run_cmd(16'h0501, 10, 3, 1'b0, 64'hCAFE, 1'b0);
    readback(CTAP_REG_SEL_DATA0, 64'hCAFE, "t2_data0");
    readback(CTAP_REG_SEL_INSTR, m_status(), "t2_status");

    // Writes while busy are dropped and flag overrun; next command clears it.
    run_cmd(16'h0402, 2, 1, 1'b0, 64'h0, 1'b1);
    readback(CTAP_REG_SEL_DATA0, m_data0, "t3_data0_kept");
    readback(CTAP_REG_SEL_INSTR, m_status(), "t3_ovr_status");
    run_cmd(16'h0401, 0, 0, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0);

    // Illegal and NOP opcodes complete without a request.
    run_cmd(16'h0907, 0, 0, 1'b0, 64'h0, 1'b0);
    readback(CTAP_REG_SEL_INSTR, m_status(), "t4_illegal_status");
    run_cmd(16'h0A00, 0, 0, 1'b0, 64'h0, 1'b0);

`ifdef CTAP_CTRL_TIMEOUT_EN
    // Timeout with no response: completion after 16 WAIT_RSP cycles.
    start_cmd(16'h0201);
    accept_req(0);
    m_tmo = 1; m_err = 1;
    exp_cpl_q.push_back(m_status());
    repeat (15) tick();
    check("tmo_busy_c15", 64'(busy), 64'(1));
    tick();
    check("tmo_int_c16", 64'(ctap_jtag_interrupt_bit), 64'(0));
    tick();
    check("tmo_int_c17", 64'(ctap_jtag_interrupt_bit), 64'(1));
    tick();
    readback(CTAP_REG_SEL_INSTR, m_status(), "tmo_status");
    // Response on the expiry cycle wins.
    run_cmd(16'h0201, 0, 15, 1'b0, 64'hBEEF_0015, 1'b0);
    readback(CTAP_REG_SEL_INSTR, m_status(), "tmo_race_status");
`else
    // Without the timer a missing response stalls indefinitely.
    run_cmd(16'h0201, 0, 40, 1'b0, 64'hBEEF_0040, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      logic [15:0] instr;
      logic [3:0]  op;
      int          r;
      if ($urandom_range(0, 2) == 0) host_write(CTAP_REG_SEL_ADDRESS, {$urandom, $urandom});
      if ($urandom_range(0, 2) == 0) host_write(CTAP_REG_SEL_DATA0, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) pulse_rsp(1'b1, {$urandom, $urandom});
      r = $urandom_range(0, 9);
      if (r < 4)       op = CTAP_OP_READ;
      else if (r < 8)  op = CTAP_OP_WRITE;
      else if (r == 8) op = CTAP_OP_NOP;
      else             op = 4'($urandom_range(3, 15));
      instr = {8'($urandom), 4'($urandom), op};
      run_cmd(instr, $urandom_range(0, 4), $urandom_range(0, 6),
              ($urandom_range(0, 3) == 0), {$urandom, $urandom}, ($urandom_range(0, 4) == 0));
      readback(CTAP_REG_SEL_DATA0, m_data0, "rnd_data0");
      readback(CTAP_REG_SEL_ADDRESS, {24'h0, m_addr}, "rnd_addr");
    end

    // Reset while a request is pending in ISSUE.
    host_write(CTAP_REG_SEL_ADDRESS, 64'hAB_CDEF_0123);
    host_write(CTAP_REG_SEL_DATA0, 64'hFEED_F00D);
    start_cmd(16'h0702);
    repeat (3) tick();
    jtag_rst_l = 1'b0;
    exp_req_q.delete();
    exp_cpl_q.delete();
    model_reset();
    tick();
    jtag_rst_l = 1'b1;
    check("midrst_req_val", 64'(req_val), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_int", 64'(ctap_jtag_interrupt_bit), 64'(0));
    check("midrst_status", ctap_jtag_data, 64'(0));
    pulse_rsp(1'b1, 64'h0BAD);
    tick();
    check("late_rsp_busy", 64'(busy), 64'(0));
    check("late_rsp_int", 64'(ctap_jtag_interrupt_bit), 64'(0));
    readback(CTAP_REG_SEL_DATA0, 64'(0), "midrst_data0");
    readback(CTAP_REG_SEL_ADDRESS, 64'(0), "midrst_addr");

    // Recovery after reset.
    run_cmd(16'h0101, 1, 2, 1'b0, 64'h7777_8888, 1'b0);
    readback(CTAP_REG_SEL_DATA0, 64'h7777_8888, "post_rst_data0");

    repeat (2) tick();
    check("req_queue_drained", 64'(exp_req_q.size()), 64'(0));
    check("cpl_queue_drained", 64'(exp_cpl_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
